// File: rtl/wb_defs_pkg.sv
// Wishbone B3 constants shared by the caches and the SDRAM port arbiter:
// cycle/burst type codes, arbiter state encoding and grant encoding.
package wb_defs;

    localparam logic [2:0] CTI_CLASSIC      = 3'b000;
    localparam logic [2:0] CTI_CONST_ADDR   = 3'b001;
    localparam logic [2:0] CTI_INC_BURST    = 3'b010;
    localparam logic [2:0] CTI_END_OF_BURST = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2,
        S_TURN = 2'd3
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // A beat that closes a transfer: last beat of a burst or a classic cycle.
    function automatic logic is_burst_boundary(input logic [2:0] cti);
        return (cti == CTI_END_OF_BURST) || (cti == CTI_CLASSIC);
    endfunction

endpackage

// File: rtl/wb_master_mux.sv
// Combinational 2:1 selector of Wishbone master request signals by one-hot
// grant; with no grant the slave sees an idle classic cycle.
module wb_master_mux
    import wb_defs::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic [1:0]    grant_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [2:0]    m0_cti_i,
    input  logic [1:0]    m0_bte_i,
    input  logic [DW-1:0] m0_dat_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [2:0]    m1_cti_i,
    input  logic [1:0]    m1_bte_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [AW-1:0] s_adr_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    output logic [DW-1:0] s_dat_o
);

    always_comb begin
        s_adr_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_cti_o = CTI_CLASSIC;
        s_bte_o = BTE_LINEAR;
        s_dat_o = '0;
        case (grant_i)
            GNT_M0: begin
                s_adr_o = m0_adr_i;
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_cti_o = m0_cti_i;
                s_bte_o = m0_bte_i;
                s_dat_o = m0_dat_i;
            end
            GNT_M1: begin
                s_adr_o = m1_adr_i;
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_cti_o = m1_cti_i;
                s_bte_o = m1_bte_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_burst_arbiter.sv
// Two-master (icache = m0, dcache = m1) to one-slave Wishbone B3 arbiter
// for the SDRAM port: burst-preserving, round-robin, with bounded hold time.
module wb_burst_arbiter
    import wb_defs::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_adr_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [2:0]    m0_cti_i,
    input  logic [1:0]    m0_bte_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic [AW-1:0] m1_adr_i,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [2:0]    m1_cti_i,
    input  logic [1:0]    m1_bte_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [AW-1:0] s_adr_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [3:0]    s_sel_o,
    output logic [2:0]    s_cti_o,
    output logic [1:0]    s_bte_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    input  logic          s_err_i,
    output logic [1:0]    grant_o,
    output logic [1:0]    dbg_state_o
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    arb_state_e    state_q, state_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          other_cyc;
    logic          preempt;

    // Grant is a pure decode of the registered state, so it never glitches.
    assign grant_o     = (state_q == S_GNT0) ? GNT_M0 :
                         (state_q == S_GNT1) ? GNT_M1 : GNT_NONE;
    assign dbg_state_o = state_q;

    wb_master_mux #(.AW(AW), .DW(DW)) u_mux (
        .grant_i  (grant_o),
        .m0_adr_i (m0_adr_i), .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),  .m0_sel_i (m0_sel_i), .m0_cti_i (m0_cti_i),
        .m0_bte_i (m0_bte_i), .m0_dat_i (m0_dat_i),
        .m1_adr_i (m1_adr_i), .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),  .m1_sel_i (m1_sel_i), .m1_cti_i (m1_cti_i),
        .m1_bte_i (m1_bte_i), .m1_dat_i (m1_dat_i),
        .s_adr_o  (s_adr_o),  .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),   .s_sel_o  (s_sel_o),  .s_cti_o  (s_cti_o),
        .s_bte_o  (s_bte_o),  .s_dat_o  (s_dat_o)
    );

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = (state_q == S_GNT0) && s_ack_i;
    assign m1_ack_o = (state_q == S_GNT1) && s_ack_i;
    assign m0_err_o = (state_q == S_GNT0) && s_err_i;
    assign m1_err_o = (state_q == S_GNT1) && s_err_i;

    assign other_cyc = (state_q == S_GNT0) ? m1_cyc_i : m0_cyc_i;
    // s_cti_o is the owner's cti while granted, so the boundary test needs no extra mux.
    assign preempt   = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && s_ack_i &&
                       is_burst_boundary(s_cti_o);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE, S_TURN: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = S_GNT0;
                end else if (m1_cyc_i) begin
                    state_d = S_GNT1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GNT0, S_GNT1: begin
                if (other_cyc && (hold_q != HOLD_MAX)) begin
                    hold_d = hold_q + HW'(1);
                end
                if (!s_cyc_o || preempt) begin
                    state_d = S_TURN;
                    last_d  = (state_q == S_GNT1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            hold_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// Bench for wb_burst_arbiter: per-cycle vector table plus hand-written
// preemption and asynchronous-reset sequences, checked through a queue.
module tb_wb_burst_arbiter;
    import wb_defs::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = 82;
    localparam logic [AW-1:0] M0_ADR = 32'h0000_0100;
    localparam logic [AW-1:0] M1_ADR = 32'h0000_2000;
    localparam logic [DW-1:0] M0_DAT = 32'hA0A0_A0A0;
    localparam logic [DW-1:0] M1_DAT = 32'hB1B1_B1B1;
    localparam logic [DW-1:0] S_DAT  = 32'hD00D_F00D;
    localparam logic [3:0]    M0_SEL = 4'hF;
    localparam logic [3:0]    M1_SEL = 4'h3;
    localparam logic [2:0]    CC = CTI_CLASSIC;
    localparam logic [2:0]    CI = CTI_INC_BURST;
    localparam logic [2:0]    CE = CTI_END_OF_BURST;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic [2:0] m0_cti_i, m1_cti_i, s_cti_o;
    logic [1:0] m0_bte_i, m1_bte_i, s_bte_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
    logic [1:0] grant_o, dbg_state_o;

    typedef struct {
        logic       m0c, m1c, ack, err;
        logic [2:0] cti0, cti1;
        logic [1:0] eg;
        logic       ec, ea0, ea1, ee0, ee1;
    } vec_t;

    vec_t vecs[64];
    int   n_vec = 0;
    logic [W-1:0] exp_q[$];
    int   n_applied = 0;
    int   n_miscompare = 0;

    wb_burst_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i),
        .m0_bte_i(m0_bte_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i),
        .m1_bte_i(m1_bte_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
        .s_bte_o(s_bte_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic m0c, m1c, ack, err,
                                input logic [2:0] cti0, cti1,
                                input logic [1:0] eg,
                                input logic ec, ea0, ea1, ee0, ee1);
        vec_t v;
        v.m0c = m0c; v.m1c = m1c; v.ack = ack; v.err = err;
        v.cti0 = cti0; v.cti1 = cti1; v.eg = eg;
        v.ec = ec; v.ea0 = ea0; v.ea1 = ea1; v.ee0 = ee0; v.ee1 = ee1;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vecs[n_vec] = v;
        n_vec++;
    endtask

    // Expected slave-side view from the expected owner and response gating.
    function automatic logic [W-1:0] model(input vec_t v);
        logic          we;
        logic [3:0]    sel;
        logic [2:0]    cti;
        logic [1:0]    bte;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        we = 1'b0; sel = '0; cti = CTI_CLASSIC; bte = BTE_LINEAR; adr = '0; dat = '0;
        if (v.eg == GNT_M0) begin
            sel = M0_SEL; cti = v.cti0; adr = M0_ADR; dat = M0_DAT;
        end else if (v.eg == GNT_M1) begin
            we = 1'b1; sel = M1_SEL; cti = v.cti1; bte = BTE_WRAP4; adr = M1_ADR; dat = M1_DAT;
        end
        return {v.eg, v.ec, v.ec, we, v.ea0, v.ea1, v.ee0, v.ee1, sel, cti, bte, adr, dat};
    endfunction

    function automatic logic [W-1:0] actual();
        return {grant_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
                s_sel_o, s_cti_o, s_bte_o, s_adr_o, s_dat_o};
    endfunction

    // Scoreboard
    task automatic check(input string name);
        logic [W-1:0] e, a;
        e = exp_q.pop_front();
        a = actual();
        n_applied++;
        if (a !== e) begin
            n_miscompare++;
            $display("FAIL %s: got %h required %h", name, a, e);
        end
    endtask

    // Driver
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        m0_cyc_i = v.m0c; m0_stb_i = v.m0c;
        m1_cyc_i = v.m1c; m1_stb_i = v.m1c;
        s_ack_i  = v.ack; s_err_i  = v.err;
        m0_cti_i = v.cti0; m1_cti_i = v.cti1;
        exp_q.push_back(model(v));
        #1;
        check(name);
    endtask

    initial begin
        m0_adr_i = M0_ADR; m0_we_i = 1'b0; m0_sel_i = M0_SEL; m0_bte_i = BTE_LINEAR; m0_dat_i = M0_DAT;
        m1_adr_i = M1_ADR; m1_we_i = 1'b1; m1_sel_i = M1_SEL; m1_bte_i = BTE_WRAP4;  m1_dat_i = M1_DAT;
        s_dat_i = S_DAT;

        // Reset / idle, then simultaneous request (m0 wins first)
        repeat (2) add(mk(0,0,0,0,CC,CC, GNT_NONE,0,0,0,0,0));
        add(mk(1,1,0,0,CC,CC, GNT_NONE,0,0,0,0,0));
        add(mk(1,1,1,0,CE,CC, GNT_M0,1,1,0,0,0));
        add(mk(0,1,0,0,CC,CC, GNT_M0,0,0,0,0,0));
        add(mk(0,1,0,0,CC,CC, GNT_NONE,0,0,0,0,0));
        add(mk(0,1,1,0,CC,CE, GNT_M1,1,0,1,0,0));
        add(mk(0,0,0,0,CC,CC, GNT_M1,0,0,0,0,0));
        repeat (2) add(mk(0,0,0,0,CC,CC, GNT_NONE,0,0,0,0,0));
        // Round robin: 0,1,0,1 with one empty grant cycle between owners
        add(mk(1,1,0,0,CC,CC, GNT_NONE,0,0,0,0,0));
        add(mk(1,1,1,0,CE,CC, GNT_M0,1,1,0,0,0));
        add(mk(0,1,0,0,CC,CC, GNT_M0,0,0,0,0,0));
        add(mk(1,1,0,0,CC,CC, GNT_NONE,0,0,0,0,0));
        add(mk(1,1,1,0,CC,CE, GNT_M1,1,0,1,0,0));
        add(mk(1,0,0,0,CC,CC, GNT_M1,0,0,0,0,0));
        add(mk(1,1,0,0,CC,CC, GNT_NONE,0,0,0,0,0));
        add(mk(1,1,1,0,CE,CC, GNT_M0,1,1,0,0,0));
        add(mk(0,1,0,0,CC,CC, GNT_M0,0,0,0,0,0));
        add(mk(0,1,0,0,CC,CC, GNT_NONE,0,0,0,0,0));
        add(mk(0,1,1,0,CC,CE, GNT_M1,1,0,1,0,0));
        add(mk(0,0,0,0,CC,CC, GNT_M1,0,0,0,0,0));
        add(mk(0,0,0,0,CC,CC, GNT_NONE,0,0,0,0,0));
        // Single 8-beat icache burst; stray acks with no owner are dropped
        add(mk(1,0,0,0,CI,CC, GNT_NONE,0,0,0,0,0));
        for (int b = 0; b < 8; b++)
            add(mk(1,0,1,0,(b < 7) ? CI : CE,CC, GNT_M0,1,1,0,0,0));
        add(mk(0,0,0,0,CC,CC, GNT_M0,0,0,0,0,0));
        repeat (2) add(mk(0,0,1,0,CC,CC, GNT_NONE,0,0,0,0,0));
        // Error on beat 3 of an m0 burst
        add(mk(1,0,0,0,CI,CC, GNT_NONE,0,0,0,0,0));
        repeat (2) add(mk(1,0,1,0,CI,CC, GNT_M0,1,1,0,0,0));
        add(mk(1,0,0,1,CI,CC, GNT_M0,1,0,0,1,0));
        add(mk(0,0,0,0,CC,CC, GNT_M0,0,0,0,0,0));
        repeat (2) add(mk(0,0,0,0,CC,CC, GNT_NONE,0,0,0,0,0));

        // Reset with both masters requesting: slave side must stay idle
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        s_ack_i = 1'b1; s_err_i = 1'b1; m0_cti_i = CI; m1_cti_i = CI;
        repeat (2) @(negedge clk);
        exp_q.push_back(model(mk(0,0,0,0,CC,CC, GNT_NONE,0,0,0,0,0)));
        #1;
        check("reset");
        @(negedge clk);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_ack_i = 1'b0; s_err_i = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < n_vec; i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        n_applied++;
        if ({m0_dat_o, m1_dat_o} !== {S_DAT, S_DAT}) begin
            n_miscompare++;
            $display("FAIL dat_fanout: got %h required %h", {m0_dat_o, m1_dat_o}, {S_DAT, S_DAT});
        end

        // Preemption: m1 bursts with m0 waiting, cut only at the burst end
        apply(mk(1,1,0,0,CC,CI, GNT_NONE,0,0,0,0,0), "pre_arb");
        for (int b = 1; b <= 8; b++)
            apply(mk(1,1,1,0,CC,(b < 8) ? CI : CE, GNT_M1,1,0,1,0,0), $sformatf("pre_beat%0d", b));
        apply(mk(1,1,1,0,CE,CI, GNT_NONE,0,0,0,0,0), "pre_turn");
        apply(mk(1,1,1,0,CE,CI, GNT_M0,1,1,0,0,0), "pre_m0");
        apply(mk(0,1,0,0,CC,CI, GNT_M0,0,0,0,0,0), "pre_m0_done");
        apply(mk(0,1,0,0,CC,CI, GNT_NONE,0,0,0,0,0), "pre_turn2");
        apply(mk(0,1,1,0,CC,CE, GNT_M1,1,0,1,0,0), "pre_m1_again");
        apply(mk(0,0,0,0,CC,CC, GNT_M1,0,0,0,0,0), "pre_m1_done");

        // Asynchronous reset in the middle of a burst
        apply(mk(1,0,0,0,CI,CC, GNT_NONE,0,0,0,0,0), "mid_arb");
        apply(mk(1,0,1,0,CI,CC, GNT_M0,1,1,0,0,0), "mid_beat");
        #2;
        rst = 1'b0;
        exp_q.push_back(model(mk(1,0,1,0,CI,CC, GNT_NONE,0,0,0,0,0)));
        #1;
        check("async_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule

// File: doc/wb_burst_arbiter.md
Name: wb_burst_arbiter

Overview:
- Two-master to one-slave Wishbone B3 arbiter sharing the single SDRAM WB port between the instruction cache (master 0) and the data cache (master 1).
- Burst-aware: a grant is held for the whole cycle (cyc high), so incrementing bursts are never split.
- Round-robin fairness on contention, with one idle turnaround cycle between owners.
- Sits between icache_wb / dcache and the SDRAM controller.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_HOLD, 64, maximum cycles one master may keep the grant while the other requests. 0 disables the limit.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- m0_adr_i, m1_adr_i  in  AW each  master address
- m0_cyc_i, m1_cyc_i  in  1 each  master cycle / request
- m0_stb_i, m1_stb_i  in  1 each  master strobe
- m0_we_i, m1_we_i  in  1 each  write enable
- m0_sel_i, m1_sel_i  in  4 each  byte select
- m0_cti_i, m1_cti_i  in  3 each  cycle type
- m0_bte_i, m1_bte_i  in  2 each  burst type
- m0_dat_i, m1_dat_i  in  DW each  write data
- m0_dat_o, m1_dat_o  out  DW each  read data, slave dat_i fanned out to both
- m0_ack_o, m1_ack_o  out  1 each  ack, gated by grant
- m0_err_o, m1_err_o  out  1 each  err, gated by grant
- s_adr_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_cti_o, s_bte_o, s_dat_o  out  as master  muxed request to slave
- s_dat_i, s_ack_i, s_err_i  in  DW/1/1  slave response
- grant_o  out  2  one-hot current owner, 00 = none

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_IDLE, grant_o=00, last=1 (master 0 wins first contention), hold_ctr=0.
  - Slave cyc/stb/we and sel are forced 0; cti=CTI_CLASSIC; bte=BTE_LINEAR.
- States: S_IDLE, S_GNT0, S_GNT1, S_TURN.
- S_IDLE:
  - Only m0_cyc_i → S_GNT0. Only m1_cyc_i → S_GNT1.
  - Both → the master that is not `last`.
  - Grant is registered, so a cyc seen in cycle N drives s_cyc_o in N+1. Minimum arbitration latency is 1 cycle.
- S_GNTx:
  - All s_* outputs are combinational muxes of master x.
  - mx_ack_o = s_ack_i; mx_err_o = s_err_i. The other master sees ack=0, err=0.
  - Exit to S_TURN when mx_cyc_i falls; set last=x.
- Forced release when MAX_HOLD≠0:
  - hold_ctr counts granted cycles while the other master has cyc high.
  - At MAX_HOLD, the arbiter waits for a boundary: the current ack with cti=CTI_END_OF_BURST or CTI_CLASSIC.
  - It then drops s_cyc_o/s_stb_o for that master (masked), goes to S_TURN and sets last=x.
  - The preempted master still has cyc high; it sees no acks until it is granted again.
- S_TURN:
  - One cycle with slave cyc=0, stb=0, then → S_IDLE evaluation.
  - Guarantees the SDRAM controller sees cyc deassert between owners.
- Ungranted master dropping cyc: no effect.
- s_ack_i while no grant: discarded.
- s_err_i during a grant: passed to the owner. The owner terminates, and the arbiter releases on cyc fall as normal.
- hold_ctr saturates at MAX_HOLD and clears on every grant change.
- Reset mid-burst: the slave cyc drops immediately (asynchronous). The slave is responsible for aborting the burst.

Decomposition:
- Shared package wb_defs: CTI_* and BTE_* localparams, the state encodings, and the arbiter grant encoding. These constants are currently duplicated inside the icache.
- One natural sub-module, wb_master_mux: a purely combinational 2:1 mux of the master request signals, selected by grant_o. The FSM and counters stay in the top module.

Test Plan:
- Reset then idle: rst=0 → all s_* zero, grant_o=00. Release rst with no cyc → s_cyc_o stays 0.
- Single icache burst: m0 asserts cyc/stb at adr 0x100 with CTI_INC_BURST.
  - s_cyc_o follows 1 cycle later with adr 0x100.
  - 8 acks route to m0_ack_o only; m1_ack_o stays 0.
  - After m0 cyc falls: one S_TURN cycle, then grant_o=00.
- Simultaneous request after reset: m0 and m1 both raise cyc in the same cycle.
  - Master 0 is granted first.
  - After its release and one turnaround, master 1 is granted with its address 0x2000 on s_adr_o.
- Round-robin fairness: both masters request continuously for 4 transactions → grant sequence 0,1,0,1, with exactly one idle cycle between each.
- MAX_HOLD preemption: MAX_HOLD=4, m1 holds cyc with repeated 8-beat bursts while m0 requests.
  - m1 is cut at the first CTI_END_OF_BURST ack after 4 held cycles.
  - m0 is granted after the turnaround.
- Error path: slave asserts s_err_i on beat 3 of an m0 burst → m0_err_o=1 that cycle, m1_err_o=0. The arbiter releases when m0 drops cyc.
